// File: rtl/msg_receiver_pkg.sv
// Shared definitions for the message receiver: default widths, FSM encodings
// and the header-build helper used by message sources.
package msg_receiver_pkg;

  localparam int MSG_W   = 32;
  localparam int LEN_W   = 8;
  localparam int TYPE_W  = 8;
  localparam int HDR_BIT = MSG_W - 1;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_BODY = 2'd1,
    W_DROP = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_HDR  = 2'd1,
    R_BODY = 2'd2
  } rd_state_e;

  function automatic logic [MSG_W-1:0] mk_hdr(input logic [LEN_W-1:0]  len,
                                              input logic [TYPE_W-1:0] typ);
    logic [MSG_W-1:0] h;
    h                       = '0;
    h[HDR_BIT]              = 1'b1;
    h[MSG_W-2 -: LEN_W]     = len;
    h[TYPE_W-1:0]           = typ;
    return h;
  endfunction

endpackage

// File: rtl/msg_receiver_if.sv
// Message bus plus replay port; master = source/consumer side, slave = receiver.
interface msg_receiver_if
  import msg_receiver_pkg::*;
#(
  parameter int MSG_WIDTH  = MSG_W,
  parameter int TYPE_WIDTH = TYPE_W
);

  logic [MSG_WIDTH-1:0]  in_msg;
  logic                  in_msg_nd;
  logic                  out_rdy;
  logic [MSG_WIDTH-2:0]  out_data;
  logic [TYPE_WIDTH-1:0] out_type;
  logic                  out_first;
  logic                  out_last;
  logic                  out_nd;
  logic                  error;

  modport master (
    output in_msg, in_msg_nd, out_rdy,
    input  out_data, out_type, out_first, out_last, out_nd, error
  );

  modport slave (
    input  in_msg, in_msg_nd, out_rdy,
    output out_data, out_type, out_first, out_last, out_nd, error
  );

endinterface

// File: rtl/msg_receiver_buffer.sv
// Packet store: simple dual-port RAM, one write port, registered read port.
module msg_receiver_buffer #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // No reset on the array or read register so the RAM maps onto block memory.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/msg_receiver.sv
// Header-framed message sink: validates packets, stores complete ones, replays them.
// Build option MSG_RECEIVER_CHECKSUM_EN: last body word is an XOR checksum of the payload.
//
// state  | meaning
// W_IDLE | waiting for a header
// W_BODY | storing body words of an accepted packet
// W_DROP | swallowing body words of a rejected packet
// R_IDLE | waiting for a committed packet
// R_HDR  | header read back, latching length/type
// R_BODY | replaying body words under out_rdy
module msg_receiver
  import msg_receiver_pkg::*;
#(
  parameter int MSG_WIDTH  = MSG_W,
  parameter int LEN_WIDTH  = LEN_W,
  parameter int TYPE_WIDTH = TYPE_W,
  parameter int BUF_DEPTH  = 64
) (
  input logic           clk,
  input logic           rst_n,
  msg_receiver_if.slave bus
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int PW = AW + 1;

`ifdef MSG_RECEIVER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
  localparam int MIN_LEN = 2;
`else
  localparam bit CSUM_EN = 1'b0;
  localparam int MIN_LEN = 1;
`endif

  wr_state_e w_state_q, w_state_d;
  rd_state_e r_state_q, r_state_d;

  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        wr_tmp_q, wr_tmp_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [LEN_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
  logic [LEN_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic [MSG_WIDTH-2:0] csum_q, csum_d;
  logic [TYPE_WIDTH-1:0] rd_type_q, rd_type_d;
  logic                 first_pend_q, first_pend_d;
  logic                 out_nd_q, out_nd_d;
  logic                 out_first_q, out_first_d;
  logic                 out_last_q, out_last_d;
  logic                 error_q, error_d;

  logic                 we;
  logic [AW-1:0]        waddr;
  logic                 re;
  logic [MSG_WIDTH-1:0] rdata;

  logic                 hdr_v, body_v, len_ok, fits;
  logic [LEN_WIDTH-1:0] hdr_len, rd_hdr_len;
  logic [MSG_WIDTH-2:0] payload;
  logic [PW-1:0]        used;
  logic [31:0]          free_w, need_w;
  logic                 unused_rd_marker;

  assign hdr_v   = bus.in_msg_nd &  bus.in_msg[MSG_WIDTH-1];
  assign body_v  = bus.in_msg_nd & ~bus.in_msg[MSG_WIDTH-1];
  assign hdr_len = bus.in_msg[MSG_WIDTH-2 -: LEN_WIDTH];
  assign payload = bus.in_msg[MSG_WIDTH-2:0];

  // A new header always restarts at the committed pointer, so occupancy is measured from there.
  assign used   = wr_ptr_q - rd_ptr_q;
  assign free_w = 32'(BUF_DEPTH) - 32'(used);
  assign need_w = 32'(hdr_len) + 32'd1;
  assign fits   = need_w <= free_w;
  assign len_ok = hdr_len >= LEN_WIDTH'(MIN_LEN);

  assign rd_hdr_len       = rdata[MSG_WIDTH-2 -: LEN_WIDTH];
  assign unused_rd_marker = rdata[MSG_WIDTH-1];

  msg_receiver_buffer #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (MSG_WIDTH)
  ) u_buffer (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (bus.in_msg),
    .re_i    (re),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q    <= W_IDLE;
      r_state_q    <= R_IDLE;
      wr_ptr_q     <= '0;
      wr_tmp_q     <= '0;
      rd_ptr_q     <= '0;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      csum_q       <= '0;
      rd_type_q    <= '0;
      first_pend_q <= 1'b0;
      out_nd_q     <= 1'b0;
      out_first_q  <= 1'b0;
      out_last_q   <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      w_state_q    <= w_state_d;
      r_state_q    <= r_state_d;
      wr_ptr_q     <= wr_ptr_d;
      wr_tmp_q     <= wr_tmp_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      csum_q       <= csum_d;
      rd_type_q    <= rd_type_d;
      first_pend_q <= first_pend_d;
      out_nd_q     <= out_nd_d;
      out_first_q  <= out_first_d;
      out_last_q   <= out_last_d;
      error_q      <= error_d;
    end
  end

  always_comb begin : wr_next
    w_state_d = w_state_q;
    if (hdr_v) begin
      if (!len_ok)   w_state_d = W_IDLE;
      else if (fits) w_state_d = W_BODY;
      else           w_state_d = W_DROP;
    end else if (body_v && (w_state_q != W_IDLE) && (wr_cnt_q == LEN_WIDTH'(1))) begin
      w_state_d = W_IDLE;
    end
  end

  always_comb begin : wr_out
    we       = 1'b0;
    waddr    = wr_tmp_q[AW-1:0];
    wr_tmp_d = wr_tmp_q;
    wr_ptr_d = wr_ptr_q;
    wr_cnt_d = wr_cnt_q;
    csum_d   = csum_q;
    error_d  = 1'b0;
    if (hdr_v) begin
      // Any header in mid-packet truncates it; the partial body is abandoned by rewinding.
      error_d  = (w_state_q != W_IDLE) || !len_ok || !fits;
      wr_tmp_d = wr_ptr_q;
      csum_d   = '0;
      if (len_ok) wr_cnt_d = hdr_len;
      if (len_ok && fits) begin
        we       = 1'b1;
        waddr    = wr_ptr_q[AW-1:0];
        wr_tmp_d = wr_ptr_q + PW'(1);
      end
    end else if (body_v) begin
      unique case (w_state_q)
        W_BODY: begin
          we       = 1'b1;
          wr_tmp_d = wr_tmp_q + PW'(1);
          wr_cnt_d = wr_cnt_q - LEN_WIDTH'(1);
          csum_d   = csum_q ^ payload;
          if (wr_cnt_q == LEN_WIDTH'(1)) begin
            if (CSUM_EN && (csum_q != payload)) begin
              error_d  = 1'b1;
              wr_tmp_d = wr_ptr_q;
            end else begin
              wr_ptr_d = wr_tmp_q + PW'(1);
            end
          end
        end
        W_DROP:  wr_cnt_d = wr_cnt_q - LEN_WIDTH'(1);
        default: error_d  = 1'b1;
      endcase
    end
  end

  always_comb begin : rd_next
    r_state_d = r_state_q;
    unique case (r_state_q)
      R_IDLE:  if (rd_ptr_q != wr_ptr_q) r_state_d = R_HDR;
      R_HDR:   r_state_d = R_BODY;
      R_BODY:  if (bus.out_rdy && (rd_cnt_q == LEN_WIDTH'(1))) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin : rd_out
    re           = 1'b0;
    rd_ptr_d     = rd_ptr_q;
    rd_cnt_d     = rd_cnt_q;
    rd_type_d    = rd_type_q;
    first_pend_d = first_pend_q;
    out_nd_d     = 1'b0;
    out_first_d  = 1'b0;
    out_last_d   = 1'b0;
    unique case (r_state_q)
      R_IDLE: re = (rd_ptr_q != wr_ptr_q);
      R_HDR: begin
        rd_type_d    = rdata[TYPE_WIDTH-1:0];
        rd_cnt_d     = CSUM_EN ? rd_hdr_len - LEN_WIDTH'(1) : rd_hdr_len;
        rd_ptr_d     = rd_ptr_q + PW'(1);
        first_pend_d = 1'b1;
      end
      R_BODY: begin
        if (bus.out_rdy) begin
          re           = 1'b1;
          out_nd_d     = 1'b1;
          out_first_d  = first_pend_q;
          out_last_d   = (rd_cnt_q == LEN_WIDTH'(1));
          first_pend_d = 1'b0;
          rd_cnt_d     = rd_cnt_q - LEN_WIDTH'(1);
          // The stored checksum word is skipped, never replayed.
          rd_ptr_d     = rd_ptr_q + ((CSUM_EN && (rd_cnt_q == LEN_WIDTH'(1))) ? PW'(2) : PW'(1));
        end
      end
      default: ;
    endcase
  end

  assign bus.out_nd    = out_nd_q;
  assign bus.out_first = out_first_q;
  assign bus.out_last  = out_last_q;
  assign bus.error     = error_q;
  assign bus.out_data  = out_nd_q ? rdata[MSG_WIDTH-2:0] : '0;
  assign bus.out_type  = out_nd_q ? rd_type_q : '0;

endmodule
